disp_load_seq: RTL and testbench
================================

DISP_LOAD_SEQ -- requirements
Module: disp_load_seq

Interface
REQ-001 SHALL have parameter DATA_W, default 12, width of the display load word.
REQ-002 SHALL have parameter SEQ_DEPTH, default 8, maximum entries per sequence (power of two, >=2).
REQ-003 SHALL have parameter NUM_MODES, default 4, number of independent sequences (power of two, >=2).
REQ-004 SHALL have port clk, input, 1, the single clock; all logic on its rising edge.
REQ-005 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-006 SHALL have port switch, input, 1, board switch; each toggle (either edge) requests one sequence.
REQ-007 SHALL have port mode_sel, input, log2(NUM_MODES), sequence select, latched at trigger.
REQ-008 SHALL have port wr_en, input, 1, table write strobe.
REQ-009 SHALL have port wr_addr, input, log2(NUM_MODES*SEQ_DEPTH), table address = mode*SEQ_DEPTH + index.
REQ-010 SHALL have port wr_data, input, DATA_W+2, entry {last, dc, data}.
REQ-011 SHALL have port tx_ready, input, 1, downstream serializer accepts the word when ds&tx_ready.
REQ-012 SHALL have port load, output, DATA_W, current word.
REQ-013 SHALL have port ds, output, 1, data-strobe/valid.
REQ-014 SHALL have port dc, output, 1, data(1)/command(0) flag of the current word.
REQ-015 SHALL have ports busy and done, outputs, 1 each: busy = state not IDLE; done = one-cycle pulse at sequence end.

Function
REQ-016 SHALL implement states IDLE, FETCH, SEND, DONE.
REQ-017 SHALL detect a switch toggle by comparing the (optionally synchronised) switch with its registered previous value.
REQ-018 SHALL, in IDLE on a detected toggle, latch mode_sel, clear index to 0, go to FETCH.
REQ-019 SHALL ignore toggles while busy (no queuing).
REQ-020 SHALL, in FETCH, register table entry [mode][index] into load/dc/last, go to SEND next cycle.
REQ-021 SHALL hold ds=1 throughout SEND, keeping load and dc stable until ds&tx_ready.
REQ-022 SHALL, on transfer in SEND: if last=1 or index=SEQ_DEPTH-1 go to DONE, else index+1 and go to FETCH.
REQ-023 SHALL assert done for exactly the one DONE cycle, then return to IDLE; ds=0 in IDLE, FETCH, DONE.
REQ-024 SHALL give first ds=1 two cycles after the clock edge that registers the toggle (no-sync build).
REQ-025 SHALL write the table in one cycle when wr_en=1 and state is IDLE; writes in other states are dropped.
REQ-026 SHALL, on simultaneous wr_en and toggle in IDLE, perform the write and start the sequence; the written entry is visible to FETCH.
REQ-027 SHALL keep load and dc at last fetched value when idle (not cleared except by reset).

Reset
REQ-028 SHALL on rst=1 at a clock edge force IDLE, load=0, dc=0, ds=0, busy=0, done=0, index=0, latched mode=0, and load the edge register from current switch (no spurious trigger).
REQ-029 SHALL abort any sequence in progress on reset without a done pulse; table contents are not cleared.

Configuration
REQ-030 SHALL, with macro DISP_SEQ_SWITCH_SYNC_EN defined, insert a two-flop synchroniser on switch before edge detection, adding 2 cycles of trigger latency (first ds 4 cycles after the toggle is sampled).
REQ-031 SHALL, without DISP_SEQ_SWITCH_SYNC_EN, edge-detect switch directly with the REQ-024 latency.

Verification
REQ-032 Write mode 1 entries {0,0,0x0AE},{0,1,0x123},{1,1,0xFFF}; toggle switch with mode_sel=1, tx_ready=1 -> ds words 0x0AE(dc0),0x123(dc1),0xFFF(dc1), then one done pulse.
REQ-033 Same table, tx_ready=0 for 5 cycles in first SEND -> ds held high, load=0x0AE stable 5 cycles, advances only after tx_ready=1.
REQ-034 Mode 2 with no last bit set -> exactly 8 words sent, done after index 7.
REQ-035 Toggle switch again mid-sequence, and wr_en to mode 1 index 0 while busy -> no second sequence, table unchanged.
REQ-036 Assert rst during second SEND -> next cycle ds=0, busy=0, load=0, no done; fresh toggle replays sequence from index 0.
REQ-037 Both macro builds -> first ds at 2 vs 4 cycles after toggle-sampling edge.

Source files
------------

// File: rtl/disp_load_seq_if.sv
// Word stream from the display load sequencer to the downstream serializer.
// A word moves on any clock edge where ds and tx_ready are both high.
interface disp_load_seq_if #(
    parameter int DATA_W = 12
);
    logic [DATA_W-1:0] load;
    logic              ds;
    logic              dc;
    logic              tx_ready;

    modport master (output load, output ds, output dc, input tx_ready);
    modport slave  (input load, input ds, input dc, output tx_ready);
endinterface

// File: rtl/disp_load_seq.sv
// Display load sequencer: each switch toggle replays one stored word sequence to the serializer.
// Optional macro DISP_SEQ_SWITCH_SYNC_EN adds a two-flop synchroniser on the switch input.
module disp_load_seq #(
    parameter int DATA_W    = 12,
    parameter int SEQ_DEPTH = 8,
    parameter int NUM_MODES = 4
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   switch,
    input  logic [$clog2(NUM_MODES)-1:0]           mode_sel,
    input  logic                                   wr_en,
    input  logic [$clog2(NUM_MODES*SEQ_DEPTH)-1:0] wr_addr,
    input  logic [DATA_W+1:0]                      wr_data,
    output logic                                   busy,
    output logic                                   done,
    disp_load_seq_if.master                        tx
);
    localparam int MODE_W = $clog2(NUM_MODES);
    localparam int IDX_W  = $clog2(SEQ_DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        SEND,
        DONE
    } state_t;

    state_t              state;
    logic [MODE_W-1:0]   mode_q;
    logic [IDX_W-1:0]    idx;
    logic [DATA_W-1:0]   load_q;
    logic                dc_q;
    logic                ds_q;
    logic                last_q;
    logic                sw_cur;
    logic                sw_prev;
    logic                toggle_q;
    logic [DATA_W+1:0]   tbl [NUM_MODES*SEQ_DEPTH];
    logic [DATA_W+1:0]   entry;

`ifdef DISP_SEQ_SWITCH_SYNC_EN
    logic sync1;
    logic sync2;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= switch;
            sync2 <= switch;
        end else begin
            sync1 <= switch;
            sync2 <= sync1;
        end
    end

    assign sw_cur = sync2;
`else
    assign sw_cur = switch;
`endif

    // Reset preloads the edge register from the live switch so no trigger fires on release.
    always_ff @(posedge clk) begin
        if (rst) begin
            sw_prev  <= switch;
            toggle_q <= 1'b0;
        end else begin
            sw_prev  <= sw_cur;
            toggle_q <= sw_cur ^ sw_prev;
        end
    end

    // The table is writable only while idle and keeps its contents across reset.
    always_ff @(posedge clk) begin
        if (wr_en && state == IDLE) begin
            tbl[wr_addr] <= wr_data;
        end
    end

    assign entry = tbl[{mode_q, idx}];

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            mode_q <= '0;
            idx    <= '0;
            load_q <= '0;
            dc_q   <= 1'b0;
            ds_q   <= 1'b0;
            last_q <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (toggle_q) begin
                        mode_q <= mode_sel;
                        idx    <= '0;
                        busy   <= 1'b1;
                        state  <= FETCH;
                    end
                end
                FETCH: begin
                    load_q <= entry[DATA_W-1:0];
                    dc_q   <= entry[DATA_W];
                    last_q <= entry[DATA_W+1];
                    ds_q   <= 1'b1;
                    state  <= SEND;
                end
                SEND: begin
                    if (tx.tx_ready) begin
                        ds_q <= 1'b0;
                        if (last_q || idx == IDX_W'(SEQ_DEPTH - 1)) begin
                            done  <= 1'b1;
                            state <= DONE;
                        end else begin
                            idx   <= idx + 1'b1;
                            state <= FETCH;
                        end
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    ds_q  <= 1'b0;
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

    assign tx.load = load_q;
    assign tx.dc   = dc_q;
    assign tx.ds   = ds_q;
endmodule

// File: tb/tb_disp_load_seq.sv
// Scoreboard bench for disp_load_seq: stimulus queues expected words, a monitor checks transfers.
// Expected trigger latency follows DISP_SEQ_SWITCH_SYNC_EN.
module tb_disp_load_seq;
    localparam int DATA_W    = 12;
    localparam int SEQ_DEPTH = 8;
    localparam int NUM_MODES = 4;
`ifdef DISP_SEQ_SWITCH_SYNC_EN
    localparam int EXP_LAT = 4;
`else
    localparam int EXP_LAT = 2;
`endif

    typedef struct packed {
        logic              is_done;
        logic              dc;
        logic [DATA_W-1:0] load;
    } exp_t;

    logic              clk;
    logic              rst;
    logic              switch;
    logic [1:0]        mode_sel;
    logic              wr_en;
    logic [4:0]        wr_addr;
    logic [DATA_W+1:0] wr_data;
    logic              busy;
    logic              done;

    int   checks;
    int   errors;
    exp_t sbq[$];

    disp_load_seq_if #(.DATA_W(DATA_W)) bus ();

    disp_load_seq #(
        .DATA_W(DATA_W),
        .SEQ_DEPTH(SEQ_DEPTH),
        .NUM_MODES(NUM_MODES)
    ) dut (
        .clk(clk),
        .rst(rst),
        .switch(switch),
        .mode_sel(mode_sel),
        .wr_en(wr_en),
        .wr_addr(wr_addr),
        .wr_data(wr_data),
        .busy(busy),
        .done(done),
        .tx(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [1:0] mode);
        mode_sel = mode;
        switch   = ~switch;
    endtask

    task automatic writeEntry(input logic [4:0] addr, input logic [DATA_W+1:0] data);
        wr_en   = 1'b1;
        wr_addr = addr;
        wr_data = data;
        @(posedge clk); #1;
        wr_en   = 1'b0;
    endtask

    task automatic pushWord(input logic dc, input logic [DATA_W-1:0] load);
        sbq.push_back({1'b0, dc, load});
    endtask

    task automatic pushDone();
        sbq.push_back({1'b1, 1'b0, {DATA_W{1'b0}}});
    endtask

    task automatic pushMode1();
        pushWord(1'b0, 12'h0AE);
        pushWord(1'b1, 12'h123);
        pushWord(1'b1, 12'hFFF);
        pushDone();
    endtask

    task automatic waitDs(input string name);
        int n;
        n = 0;
        while (bus.ds !== 1'b1 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        checkOutput(name, 32'(bus.ds), 32'd1);
    endtask

    task automatic waitDone(input string name);
        int n;
        n = 0;
        while (done !== 1'b1 && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        checkOutput(name, 32'(done), 32'd1);
        repeat (2) @(posedge clk);
        #1;
        checkOutput({name, "_drained"}, 32'(sbq.size()), 32'd0);
    endtask

    // Monitor: every transfer or done pulse must match the head of the expected queue.
    initial begin
        exp_t e;
        logic [DATA_W+1:0] act;
        forever begin
            @(negedge clk);
            if (!rst && ((bus.ds && bus.tx_ready) || done)) begin
                act = {done, bus.ds ? bus.dc : 1'b0, bus.ds ? bus.load : {DATA_W{1'b0}}};
                if (sbq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_output: got %h, expected no output", act);
                end else begin
                    e = sbq.pop_front();
                    checkOutput("sb_output", 32'(act), 32'(e));
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int n;
        int rises;
        logic prev_ds;

        checks   = 0;
        errors   = 0;
        rst      = 1'b1;
        switch   = 1'b0;
        mode_sel = '0;
        wr_en    = 1'b0;
        wr_addr  = '0;
        wr_data  = '0;
        bus.tx_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_ds",   32'(bus.ds),   32'd0);
        checkOutput("reset_busy", 32'(busy),     32'd0);
        checkOutput("reset_done", 32'(done),     32'd0);
        checkOutput("reset_load", 32'(bus.load), 32'd0);
        checkOutput("reset_dc",   32'(bus.dc),   32'd0);
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("no_spurious_trigger", 32'(busy), 32'd0);

        writeEntry(5'd8,  14'h00AE);
        writeEntry(5'd9,  14'h1123);
        writeEntry(5'd10, 14'h3FFF);
        for (int i = 0; i < SEQ_DEPTH; i++) begin
            writeEntry(5'(16 + i), {1'b0, 1'(i), 12'(12'h200 + i)});
        end

        $display("[TB] mode 1 sequence with latency check");
        bus.tx_ready = 1'b1;
        pushMode1();
        applyStimulus(2'd1);
        n = 0;
        while (bus.ds !== 1'b1 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        checkOutput("first_ds_latency", 32'(n - 1), 32'(EXP_LAT));
        waitDone("mode1_done");
        checkOutput("idle_load_held", 32'(bus.load), 32'hFFF);

        $display("[TB] stall in first SEND");
        bus.tx_ready = 1'b0;
        pushMode1();
        applyStimulus(2'd1);
        waitDs("stall_ds_seen");
        for (int i = 0; i < 5; i++) begin
            checkOutput("stall_ds",   32'(bus.ds),   32'd1);
            checkOutput("stall_load", 32'(bus.load), 32'h0AE);
            @(posedge clk); #1;
        end
        bus.tx_ready = 1'b1;
        waitDone("stall_done");

        $display("[TB] mode 2 full depth");
        for (int i = 0; i < SEQ_DEPTH; i++) begin
            pushWord(1'(i), 12'(12'h200 + i));
        end
        pushDone();
        applyStimulus(2'd2);
        waitDone("mode2_done");

        $display("[TB] toggle and write while busy");
        pushMode1();
        applyStimulus(2'd1);
        waitDs("busy_ds_seen");
        switch  = ~switch;
        wr_en   = 1'b1;
        wr_addr = 5'd8;
        wr_data = 14'h0555;
        @(posedge clk); #1;
        wr_en = 1'b0;
        waitDone("busy_done");
        repeat (8) @(posedge clk);
        #1;
        checkOutput("no_second_seq", 32'(busy), 32'd0);
        pushMode1();
        applyStimulus(2'd1);
        waitDone("table_unchanged_done");

        $display("[TB] reset during second SEND");
        pushWord(1'b0, 12'h0AE);
        applyStimulus(2'd1);
        rises   = 0;
        prev_ds = 1'b0;
        n       = 0;
        while (rises < 2 && n < 50) begin
            @(posedge clk); #1;
            if (bus.ds && !prev_ds) rises++;
            prev_ds = bus.ds;
            n++;
        end
        checkOutput("second_send_seen", 32'(rises), 32'd2);
        bus.tx_ready = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        checkOutput("abort_ds",   32'(bus.ds),   32'd0);
        checkOutput("abort_busy", 32'(busy),     32'd0);
        checkOutput("abort_load", 32'(bus.load), 32'd0);
        checkOutput("abort_done", 32'(done),     32'd0);
        rst = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        checkOutput("abort_drained", 32'(sbq.size()), 32'd0);
        bus.tx_ready = 1'b1;
        pushMode1();
        applyStimulus(2'd1);
        waitDone("replay_done");

        $display("[TB] write coinciding with trigger");
        pushWord(1'b1, 12'h777);
        pushDone();
        applyStimulus(2'd3);
        wr_en   = 1'b1;
        wr_addr = 5'd24;
        wr_data = 14'h0111;
        @(posedge clk); #1;
        wr_data = 14'h3777;
        @(posedge clk); #1;
        wr_en = 1'b0;
        waitDone("simul_write_done");

        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
